// File: rtl/mult_ctrl_pkg.sv
// Shared types and widths for the time-shared 4x4 multiplier controller.
package mult_ctrl_pkg;

  localparam int unsigned OP_W              = 4;
  localparam int unsigned PROD_W            = 8;
  localparam int unsigned CNT_W             = 4;
  localparam int unsigned SETTLE_CYCLES_DEF = 1;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StResp
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first valid requester at or above the pointer, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any,
  output logic [ID_W-1:0]    o_next_ptr
);

  always_comb begin
    logic [ID_W:0]   w_cand;
    logic [ID_W-1:0] w_cand_idx;
    o_grant    = '0;
    o_idx      = '0;
    o_any      = 1'b0;
    w_cand     = '0;
    w_cand_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      // One spare bit so the wrap also works for non power-of-two NUM_REQ
      w_cand = {1'b0, i_ptr} + (ID_W + 1)'(i);
      if (w_cand >= (ID_W + 1)'(NUM_REQ)) begin
        w_cand = w_cand - (ID_W + 1)'(NUM_REQ);
      end
      w_cand_idx = ID_W'(w_cand);
      if (!o_any && i_valid[w_cand_idx]) begin
        o_any               = 1'b1;
        o_grant[w_cand_idx] = 1'b1;
        o_idx               = w_cand_idx;
      end
    end
  end

  always_comb begin
    if (32'(o_idx) == NUM_REQ - 1) begin
      o_next_ptr = '0;
    end else begin
      o_next_ptr = o_idx + ID_W'(1);
    end
  end

endmodule

// File: rtl/mult_share_ctrl.sv
// Time-shares one external 4x4 multiplier among NUM_REQ requesters with round-robin arbitration.
// Optional MULT_ZERO_BYPASS_EN: zero operands skip the multiplier and respond one cycle after accept.
module mult_share_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned ID_W          = 2,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [OP_W*NUM_REQ-1:0] req_m,
  input  logic [OP_W*NUM_REQ-1:0] req_q,
  output logic [OP_W-1:0]         mul_m,
  output logic [OP_W-1:0]         mul_q,
  input  logic [PROD_W-1:0]       mul_p,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [PROD_W-1:0]       rsp_prod,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    busy
);

  state_e              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [ID_W-1:0]     r_ptr, w_ptr_nxt;
  logic [ID_W-1:0]     r_id, w_id_nxt;
  logic [OP_W-1:0]     r_m, w_m_nxt;
  logic [OP_W-1:0]     r_q, w_q_nxt;
  logic [PROD_W-1:0]   r_prod, w_prod_nxt;

  logic [NUM_REQ-1:0]  w_grant;
  logic [ID_W-1:0]     w_gnt_idx;
  logic [ID_W-1:0]     w_ptr_inc;
  logic                w_gnt_any;
  logic [OP_W-1:0]     w_sel_m;
  logic [OP_W-1:0]     w_sel_q;
  logic                w_bypass;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .i_valid    (req_valid),
    .i_ptr      (r_ptr),
    .o_grant    (w_grant),
    .o_idx      (w_gnt_idx),
    .o_any      (w_gnt_any),
    .o_next_ptr (w_ptr_inc)
  );

  always_comb begin
    w_sel_m = '0;
    w_sel_q = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_m = req_m[i*OP_W +: OP_W];
        w_sel_q = req_q[i*OP_W +: OP_W];
      end
    end
  end

`ifdef MULT_ZERO_BYPASS_EN
  assign w_bypass = (w_sel_m == '0) || (w_sel_q == '0);
`else
  assign w_bypass = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_id_nxt    = r_id;
    w_m_nxt     = r_m;
    w_q_nxt     = r_q;
    w_prod_nxt  = r_prod;
    req_ready   = '0;
    unique case (r_state)
      StIdle: begin
        req_ready = w_grant;
        if (w_gnt_any) begin
          w_ptr_nxt = w_ptr_inc;
          w_id_nxt  = w_gnt_idx;
          if (w_bypass) begin
            // Multiplier operands left untouched to avoid needless toggling
            w_prod_nxt  = '0;
            w_state_nxt = StResp;
          end else begin
            w_m_nxt     = w_sel_m;
            w_q_nxt     = w_sel_q;
            w_cnt_nxt   = CNT_W'(SETTLE_CYCLES - 1);
            w_state_nxt = StMul;
          end
        end
      end
      StMul: begin
        if (r_cnt == '0) begin
          w_prod_nxt  = mul_p;
          w_state_nxt = StResp;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      StResp: begin
        if (rsp_ready) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_id    <= '0;
      r_m     <= '0;
      r_q     <= '0;
      r_prod  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_id    <= w_id_nxt;
      r_m     <= w_m_nxt;
      r_q     <= w_q_nxt;
      r_prod  <= w_prod_nxt;
    end
  end

  assign mul_m     = r_m;
  assign mul_q     = r_q;
  assign rsp_valid = (r_state == StResp);
  assign rsp_prod  = r_prod;
  assign rsp_id    = r_id;
  assign busy      = (r_state != StIdle);

endmodule
